cpu2core_cpu0_cpu_debug_scan_master: RTL
========================================

// Module: cpu2core_cpu0_cpu_debug_scan_master
// PURPOSE
//   Initiator end of the CPU debug-slave virtual-JTAG interface: sequences UIR/CDR/SDR/UDR/RTI
//   and a generated TCK so on-chip logic or the testbench can run DR scans on the debug slave
//   without an sld hub. Takes one {IR, DR} request, shifts DR out LSB-first on TDI while
//   capturing TDO, then returns the captured DR. Sits beside the debug slave's vji_* nets.
// PARAMETERS
//   TCK_HALF   2   TCK half-period in clk cycles (>=1)
//   IR_WIDTH   2   width of vji_ir_in / req_ir
//   DR_WIDTH   38  scan length in TCK periods (matches jdo/sr width)
//   RTI_TCKS   1   TCK periods spent in run-test-idle after UDR (>=1)
// PORTS
//   clk        in   1         system clock; all logic on rising edge
//   reset_n    in   1         asynchronous, active-low reset
//   req_valid  in   1         scan request
//   req_ready  out  1         high when IDLE; transfer on req_valid & req_ready
//   req_ir     in   IR_WIDTH  instruction presented on vji_ir_in
//   req_dr     in   DR_WIDTH  data shifted out on vji_tdi, bit 0 first
//   rsp_valid  out  1         one-cycle pulse: scan complete, rsp_dr valid
//   rsp_dr     out  DR_WIDTH  TDO bits captured, first-captured in bit 0
//   busy       out  1         ~req_ready
//   vji_tck    out  1         generated TCK
//   vji_tdi    out  1         serial data to slave
//   vji_tdo    in   1         serial data from slave
//   vji_ir_in  out  IR_WIDTH  virtual IR
//   vji_uir/vji_cdr/vji_sdr/vji_udr/vji_rti  out  1  virtual state strobes
// BEHAVIOUR
//   Reset: every output 0 except req_ready=1; state IDLE, TCK phase counter 0. Async assert
//     mid-scan aborts at once: strobes/tck/tdi low, no rsp_valid. rsp_dr, vji_ir_in -> 0.
//   TCK: held 0 in IDLE. Otherwise counter 0..TCK_HALF-1, toggles tck at terminal count.
//     "rise" = clk edge driving tck 0->1, "fall" = 1->0. Period = 2*TCK_HALF clk.
//   Accept (IDLE, req_valid): latch req_dr into tx shift reg, drive vji_ir_in=req_ir (held until
//     next accept), enter UIR, vji_uir=1 from next cycle. First rise TCK_HALF clk later.
//   FSM: IDLE -> UIR(1 period) -> CDR(1) -> SDR(DR_WIDTH) -> UDR(1) -> RTI(RTI_TCKS) -> IDLE.
//     Every state change happens on a fall edge, so each strobe is stable across >=1 rise.
//     Exactly one of uir/cdr/sdr/udr/rti is high outside IDLE; all low in IDLE.
//   SDR: vji_tdi = tx[0]; each rise: rx <= {vji_tdo, rx[DR_WIDTH-1:1]}; each fall: tx >>= 1.
//     Bit counter exits SDR on the fall after rise #DR_WIDTH. vji_tdi = 0 outside SDR.
//   Completion: on the final RTI fall: state IDLE, rsp_dr <= rx, rsp_valid=1 for one clk,
//     req_ready=1 same cycle. rsp_dr held until next completion.
//   Latency: rsp_valid is high exactly 2*TCK_HALF*(DR_WIDTH+3+RTI_TCKS) clk after the accept
//     edge (168 at defaults). Back-to-back accept allowed in the rsp_valid cycle.
//   req_valid while busy: ignored; req_* need not be held after accept.
// TESTING
//   1 Reset, idle 20 clk -> req_ready=1, all vji_* and rsp_* 0, tck static 0.
//   2 req ir=2'b01, dr=38'h2A_5A5A_5A5A, tdo=tdi sampled at rise -> rsp_dr=38'h2A_5A5A_5A5A,
//     rsp_valid at clk 168, exactly 38 rises with sdr=1, ir_in=2'b01 throughout.
//   3 tdo tied 1 / tied 0 -> rsp_dr=38'h3F_FFFF_FFFF / 38'h0; tdi follows req_dr bits LSB-first.
//   4 Strobe monitor: order uir,cdr,sdr x38,udr,rti; one-hot; each changes only on tck fall.
//   5 req_valid held high with two requests -> 2nd accepted in 1st's rsp_valid cycle; req_valid
//     pulses during busy ignored; exactly two rsp_valid pulses.
//   6 reset_n low mid-SDR (after rise 10) -> outputs cleared immediately, no rsp_valid; new
//     request afterwards completes correctly. Repeat 2 with TCK_HALF=1 -> rsp_valid at clk 84.

Source files
------------

// File: rtl/cpu2core_cpu0_cpu_debug_scan_master.sv
// Debug-slave virtual-JTAG initiator: generates TCK and walks UIR/CDR/SDR/UDR/RTI
// to shift one DR out on vji_tdi while capturing vji_tdo.
module cpu2core_cpu0_cpu_debug_scan_master #(
  parameter int unsigned TCK_HALF = 2,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned RTI_TCKS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IR_WIDTH-1:0] req_ir,
  input  logic [DR_WIDTH-1:0] req_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam int unsigned BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int unsigned RW = (RTI_TCKS > 1) ? $clog2(RTI_TCKS) : 1;
  localparam logic [CW-1:0] PH_LAST  = CW'(TCK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_TCKS - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_UIR  = 3'd1;
  localparam logic [2:0] ST_CDR  = 3'd2;
  localparam logic [2:0] ST_SDR  = 3'd3;
  localparam logic [2:0] ST_UDR  = 3'd4;
  localparam logic [2:0] ST_RTI  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       ph_q, ph_d;
  logic                tck_q, tck_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [RW-1:0]       rti_q, rti_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                tick, rise, fall;
  logic [DR_WIDTH:0]   rx_shift;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    tck_d       = tck_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    rti_d       = rti_q;
    ir_d        = ir_q;
    rsp_dr_d    = rsp_dr_q;
    rsp_valid_d = 1'b0;

    tick     = (state_q != ST_IDLE) && (ph_q == PH_LAST);
    rise     = tick && !tck_q;
    fall     = tick && tck_q;
    rx_shift = {vji_tdo, rx_q};

    if (state_q == ST_IDLE) begin
      ph_d  = '0;
      tck_d = 1'b0;
      if (req_valid) begin
        state_d = ST_UIR;
        tx_d    = req_dr;
        ir_d    = req_ir;
        bit_d   = '0;
        rti_d   = '0;
      end
    end else begin
      ph_d = tick ? '0 : ph_q + 1'b1;
      if (tick) tck_d = ~tck_q;
      // State changes only on TCK falls so each strobe spans a full rise.
      case (state_q)
        ST_UIR: if (fall) state_d = ST_CDR;
        ST_CDR: if (fall) begin
          state_d = ST_SDR;
          bit_d   = '0;
        end
        ST_SDR: begin
          if (rise) rx_d = rx_shift[DR_WIDTH:1];
          if (fall) begin
            tx_d = tx_q >> 1;
            if (bit_q == BIT_LAST) state_d = ST_UDR;
            else                   bit_d   = bit_q + 1'b1;
          end
        end
        ST_UDR: if (fall) begin
          state_d = ST_RTI;
          rti_d   = '0;
        end
        ST_RTI: if (fall) begin
          if (rti_q == RTI_LAST) begin
            state_d     = ST_IDLE;
            rsp_dr_d    = rx_q;
            rsp_valid_d = 1'b1;
          end else begin
            rti_d = rti_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      tck_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      rti_q       <= '0;
      ir_q        <= '0;
      rsp_dr_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      tck_q       <= tck_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      rti_q       <= rti_d;
      ir_q        <= ir_d;
      rsp_dr_q    <= rsp_dr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = (state_q == ST_SDR) & tx_q[0];
  assign vji_ir_in = ir_q;
  assign vji_uir   = (state_q == ST_UIR);
  assign vji_cdr   = (state_q == ST_CDR);
  assign vji_sdr   = (state_q == ST_SDR);
  assign vji_udr   = (state_q == ST_UDR);
  assign vji_rti   = (state_q == ST_RTI);

endmodule
